// File: rtl/C.sv
// Core-wide configuration constants shared by the rename and commit blocks.
package C;
  localparam int NR_COMMIT_PORTS = 2;
endpackage

// File: rtl/preg_freelist.sv
// Physical register free list: circular buffer of free preg ids with a
// speculative head for rename, a committed head for recovery and a free tail.
module preg_freelist #(
  parameter int PRF_SIZE    = 64,
  parameter int NR_RESERVED = 32,
  parameter int NR_ALLOC    = 2,
  parameter int NR_FREE     = C::NR_COMMIT_PORTS
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NR_ALLOC-1:0]                       alloc_req_i,
  output logic [NR_ALLOC-1:0]                       alloc_gnt_o,
  output logic [NR_ALLOC*$clog2(PRF_SIZE)-1:0]      alloc_id_o,
  input  logic [NR_ALLOC-1:0]                       retire_i,
  input  logic [NR_FREE-1:0]                        free_valid_i,
  input  logic [NR_FREE*$clog2(PRF_SIZE)-1:0]       free_id_i,
  input  logic                                      flush_i,
  output logic [$clog2(PRF_SIZE-NR_RESERVED+1)-1:0] count_o,
  output logic                                      empty_o,
  output logic                                      overflow_o
);

  localparam int DEPTH = PRF_SIZE - NR_RESERVED;
  localparam int IDW   = $clog2(PRF_SIZE);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDW-1:0] mem_q [DEPTH];
  logic [IDW-1:0] mem_d [DEPTH];
  logic [PW-1:0]  tail_q, tail_d;
  logic [PW-1:0]  sh_q, sh_d;
  logic [PW-1:0]  ch_q, ch_d;
  // count_q: speculatively free entries; unc_q: allocated but not yet retired
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  unc_q, unc_d;
  logic           overflow_q, overflow_d;

  logic [CW-1:0]  k, r, r_ok, kg, acc, rank;
  logic [CW:0]    occ, occ_w, flush_cnt;
  logic           grant_ok, ret_err, ovf_free;

  // Pointer advance modulo DEPTH; the increment never exceeds DEPTH.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
    logic [CW:0] s;
    s = {{(CW-PW+1){1'b0}}, p} + {1'b0, n};
    if (s >= (CW+1)'(DEPTH)) s = s - (CW+1)'(DEPTH);
    return s[PW-1:0];
  endfunction

  function automatic logic [CW-1:0] popcnt_a(input logic [NR_ALLOC-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NR_ALLOC; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  always_comb begin
    k        = popcnt_a(alloc_req_i);
    r        = popcnt_a(retire_i);
    // Grants are all-or-nothing and are masked while reset is held.
    grant_ok = rst_ni && !flush_i && (count_q != '0) && (k != '0) && (k <= count_q);
    kg       = grant_ok ? k : '0;

    alloc_gnt_o = grant_ok ? alloc_req_i : '0;
    alloc_id_o  = '0;
    rank        = '0;
    for (int i = 0; i < NR_ALLOC; i++) begin
      alloc_id_o[i*IDW +: IDW] = mem_q[ptr_add(sh_q, rank)];
      if (alloc_req_i[i]) rank = rank + CW'(1);
    end
  end

  // Frees land at the tail in port order; one that would overfill is dropped.
  always_comb begin
    mem_d    = mem_q;
    acc      = '0;
    ovf_free = 1'b0;
    occ      = {1'b0, count_q} + {1'b0, unc_q};
    occ_w    = occ;
    for (int j = 0; j < NR_FREE; j++) begin
      if (free_valid_i[j]) begin
        occ_w = occ + {1'b0, acc};
        if (occ_w < (CW+1)'(DEPTH)) begin
          mem_d[ptr_add(tail_q, acc)] = free_id_i[j*IDW +: IDW];
          acc = acc + CW'(1);
        end else begin
          ovf_free = 1'b1;
        end
      end
    end
    tail_d = ptr_add(tail_q, acc);
  end

  always_comb begin
    ret_err    = (r > unc_q);
    r_ok       = ret_err ? '0 : r;
    ch_d       = ptr_add(ch_q, r_ok);
    overflow_d = overflow_q | ovf_free | ret_err;
    flush_cnt  = occ - {1'b0, r_ok} + {1'b0, acc};
    if (flush_i) begin
      // Everything between the committed head and the tail becomes free again.
      sh_d    = ch_d;
      unc_d   = '0;
      count_d = flush_cnt[CW-1:0];
    end else begin
      sh_d    = ptr_add(sh_q, kg);
      unc_d   = unc_q + kg - r_ok;
      count_d = count_q - kg + acc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < DEPTH; j++) mem_q[j] <= IDW'(NR_RESERVED + j);
      tail_q     <= '0;
      sh_q       <= '0;
      ch_q       <= '0;
      count_q    <= CW'(DEPTH);
      unc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      tail_q     <= tail_d;
      sh_q       <= sh_d;
      ch_q       <= ch_d;
      count_q    <= count_d;
      unc_q      <= unc_d;
      overflow_q <= overflow_d;
    end
  end

  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_preg_freelist.sv
// Directed bench for preg_freelist with hand-computed expectations.
module tb_preg_freelist;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  alloc_req;
  logic [1:0]  alloc_gnt;
  logic [11:0] alloc_id;
  logic [1:0]  retire;
  logic [1:0]  free_valid;
  logic [11:0] free_id;
  logic        flush;
  logic [5:0]  count;
  logic        empty;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  preg_freelist dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .alloc_req_i (alloc_req),
    .alloc_gnt_o (alloc_gnt),
    .alloc_id_o  (alloc_id),
    .retire_i    (retire),
    .free_valid_i(free_valid),
    .free_id_i   (free_id),
    .flush_i     (flush),
    .count_o     (count),
    .empty_o     (empty),
    .overflow_o  (overflow)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alloc_req  = 2'b00;
    retire     = 2'b00;
    free_valid = 2'b00;
    free_id    = 12'd0;
    flush      = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    alloc_req = 2'b11;
    #12;
    n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL reset_count got %0d want 32", count); end
    n_cmp++; if (empty !== 1'b0) begin n_bad++; $display("FAIL reset_empty got %b want 0", empty); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got %b want 00", alloc_gnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (alloc_gnt !== 2'b11) begin n_bad++; $display("FAIL post_reset_gnt got %b want 11", alloc_gnt); end
    n_cmp++; if (alloc_id !== {6'd33, 6'd32}) begin n_bad++; $display("FAIL post_reset_ids got %h want %h", alloc_id, {6'd33, 6'd32}); end
    idle();
  endtask

  task automatic test_alloc();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      alloc_req = 2'b11;
      #2;
      n_cmp++; if (alloc_gnt !== 2'b11) begin n_bad++; $display("FAIL alloc_gnt[%0d] got %b want 11", c, alloc_gnt); end
      n_cmp++; if (alloc_id[5:0] !== 6'(32 + 2*c)) begin n_bad++; $display("FAIL alloc_id0[%0d] got %0d want %0d", c, alloc_id[5:0], 32 + 2*c); end
      n_cmp++; if (alloc_id[11:6] !== 6'(33 + 2*c)) begin n_bad++; $display("FAIL alloc_id1[%0d] got %0d want %0d", c, alloc_id[11:6], 33 + 2*c); end
      n_cmp++; if (count !== 6'(32 - 2*c)) begin n_bad++; $display("FAIL alloc_count[%0d] got %0d want %0d", c, count, 32 - 2*c); end
      tick();
    end
    idle();
    #2;
    n_cmp++; if (count !== 6'd26) begin n_bad++; $display("FAIL alloc_count_end got %0d want 26", count); end
  endtask

  task automatic test_all_or_nothing();
    do_reset();
    alloc_req = 2'b11;
    for (int c = 0; c < 15; c++) tick();
    alloc_req = 2'b01;
    tick();
    alloc_req = 2'b11;
    #2;
    n_cmp++; if (count !== 6'd1) begin n_bad++; $display("FAIL aon_count1 got %0d want 1", count); end
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL aon_gnt_short got %b want 00", alloc_gnt); end
    tick();
    n_cmp++; if (count !== 6'd1) begin n_bad++; $display("FAIL aon_count_hold got %0d want 1", count); end
    alloc_req = 2'b10;
    #2;
    n_cmp++; if (alloc_gnt !== 2'b10) begin n_bad++; $display("FAIL aon_gnt_port1 got %b want 10", alloc_gnt); end
    n_cmp++; if (alloc_id[11:6] !== 6'd63) begin n_bad++; $display("FAIL aon_id_port1 got %0d want 63", alloc_id[11:6]); end
    tick();
    alloc_req = 2'b11;
    #2;
    n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL aon_count0 got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL aon_empty got %b want 1", empty); end
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL aon_gnt_empty got %b want 00", alloc_gnt); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 2'b11;
    tick();
    tick();
    idle();
    retire = 2'b11;
    tick();
    idle();
    flush = 1'b1;
    alloc_req = 2'b01;
    #2;
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL flush_gnt got %b want 00", alloc_gnt); end
    tick();
    idle();
    alloc_req = 2'b01;
    #2;
    n_cmp++; if (count !== 6'd30) begin n_bad++; $display("FAIL flush_count got %0d want 30", count); end
    n_cmp++; if (alloc_gnt !== 2'b01) begin n_bad++; $display("FAIL flush_gnt2 got %b want 01", alloc_gnt); end
    n_cmp++; if (alloc_id[5:0] !== 6'd34) begin n_bad++; $display("FAIL flush_id got %0d want 34", alloc_id[5:0]); end
    idle();
  endtask

  task automatic test_free_empty();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      alloc_req = 2'b11;
      retire = (c > 0) ? 2'b11 : 2'b00;
      tick();
    end
    idle();
    retire = 2'b11;
    tick();
    idle();
    free_valid = 2'b01;
    free_id = {6'd0, 6'd7};
    alloc_req = 2'b01;
    #2;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fe_empty got %b want 1", empty); end
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL fe_gnt_same got %b want 00", alloc_gnt); end
    tick();
    idle();
    alloc_req = 2'b01;
    #2;
    n_cmp++; if (count !== 6'd1) begin n_bad++; $display("FAIL fe_count got %0d want 1", count); end
    n_cmp++; if (alloc_gnt !== 2'b01) begin n_bad++; $display("FAIL fe_gnt_next got %b want 01", alloc_gnt); end
    n_cmp++; if (alloc_id[5:0] !== 6'd7) begin n_bad++; $display("FAIL fe_id got %0d want 7", alloc_id[5:0]); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fe_ovf got %b want 0", overflow); end
    idle();
  endtask

  task automatic test_overflow();
    do_reset();
    free_valid = 2'b01;
    free_id = {6'd0, 6'd3};
    tick();
    idle();
    #2;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", overflow); end
    n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL ovf_count got %0d want 32", count); end
    tick();
    tick();
    alloc_req = 2'b01;
    #2;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    n_cmp++; if (alloc_id[5:0] !== 6'd32) begin n_bad++; $display("FAIL ovf_dropped_id got %0d want 32", alloc_id[5:0]); end
    idle();
  endtask

  task automatic test_retire_err();
    do_reset();
    retire = 2'b01;
    tick();
    idle();
    #2;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL rerr_ovf got %b want 1", overflow); end
    alloc_req = 2'b11;
    tick();
    idle();
    retire = 2'b11;
    tick();
    idle();
    flush = 1'b1;
    tick();
    idle();
    alloc_req = 2'b01;
    #2;
    n_cmp++; if (alloc_id[5:0] !== 6'd34) begin n_bad++; $display("FAIL rerr_ch_id got %0d want 34", alloc_id[5:0]); end
    n_cmp++; if (count !== 6'd30) begin n_bad++; $display("FAIL rerr_count got %0d want 30", count); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_req = 2'b11;
    tick();
    tick();
    idle();
    retire = 2'b11;
    tick();
    retire = 2'b01;
    free_valid = 2'b11;
    free_id = {6'd41, 6'd40};
    tick();
    idle();
    #2;
    n_cmp++; if (count !== 6'd30) begin n_bad++; $display("FAIL b2b_count got %0d want 30", count); end
    for (int c = 0; c < 14; c++) begin
      alloc_req = 2'b11;
      #2;
      n_cmp++; if (alloc_id !== {6'(37 + 2*c), 6'(36 + 2*c)}) begin n_bad++; $display("FAIL b2b_ids[%0d] got %h want %h", c, alloc_id, {6'(37 + 2*c), 6'(36 + 2*c)}); end
      tick();
    end
    alloc_req = 2'b11;
    #2;
    n_cmp++; if (alloc_gnt !== 2'b11) begin n_bad++; $display("FAIL b2b_wrap_gnt got %b want 11", alloc_gnt); end
    n_cmp++; if (alloc_id !== {6'd41, 6'd40}) begin n_bad++; $display("FAIL b2b_wrap_ids got %h want %h", alloc_id, {6'd41, 6'd40}); end
    idle();
  endtask

  task automatic test_reset_midburst();
    do_reset();
    free_valid = 2'b01;
    free_id = {6'd0, 6'd3};
    tick();
    alloc_req = 2'b11;
    free_valid = 2'b00;
    for (int c = 0; c < 6; c++) tick();
    #1;
    n_cmp++; if (count !== 6'd20) begin n_bad++; $display("FAIL mid_count_pre got %0d want 20", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL mid_ovf_pre got %b want 1", overflow); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL mid_count got %0d want 32", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_ovf got %b want 0", overflow); end
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL mid_gnt got %b want 00", alloc_gnt); end
    alloc_req = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (alloc_gnt !== 2'b01) begin n_bad++; $display("FAIL mid_gnt_after got %b want 01", alloc_gnt); end
    n_cmp++; if (alloc_id[5:0] !== 6'd32) begin n_bad++; $display("FAIL mid_id got %0d want 32", alloc_id[5:0]); end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_alloc();
    test_all_or_nothing();
    test_flush();
    test_free_empty();
    test_overflow();
    test_retire_err();
    test_back_to_back();
    test_reset_midburst();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/preg_freelist.md
PREG_FREELIST -- requirements
Module: preg_freelist

Interface
REQ-001 SHALL have parameter PRF_SIZE, default 64: number of physical registers.
REQ-002 SHALL have parameter NR_RESERVED, default 32: preg ids 0..NR_RESERVED-1 are owned by the architectural map at reset and are not in the list.
REQ-003 SHALL have parameter NR_ALLOC, default 2: rename allocation ports.
REQ-004 SHALL have parameter NR_FREE, default C::NR_COMMIT_PORTS: commit free ports.
REQ-005 SHALL derive localparams DEPTH = PRF_SIZE-NR_RESERVED and IDW = $clog2(PRF_SIZE).
REQ-006 SHALL have ports:
- clk_i  in  1  clock, one clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- alloc_req_i  in  NR_ALLOC  per-port allocation request.
- alloc_gnt_o  out  NR_ALLOC  per-port grant.
- alloc_id_o  out  NR_ALLOC x IDW  granted preg id, valid when the grant bit is 1.
- retire_i  in  NR_ALLOC  count of speculative allocations now committed (popcount used).
- free_valid_i  in  NR_FREE  per-port free strobe.
- free_id_i  in  NR_FREE x IDW  preg id returned to the list.
- flush_i  in  1  squash all uncommitted allocations.
- count_o  out  $clog2(DEPTH+1)  speculatively free entries.
- empty_o  out  1  count_o == 0.
- overflow_o  out  1  sticky error flag.

Function
REQ-007 SHALL store the ids in a circular buffer of DEPTH entries with tail pointer T, speculative head SH and committed head CH, all modulo DEPTH (DEPTH need not be a power of 2).
REQ-008 SHALL let K = popcount(alloc_req_i) and grant all requesting ports only when K <= count_o and flush_i == 0; otherwise it SHALL grant no port (all-or-nothing).
REQ-009 SHALL assign ids to granted ports in ascending port order: the i-th requesting port gets entry SH+i, presented combinationally in the same cycle.
REQ-010 SHALL advance SH by K on the next clock edge after a grant.
REQ-011 SHALL write each valid free, in ascending port order, at T, T+1, ...; T advances by popcount(free_valid_i) on the next edge.
REQ-012 SHALL NOT bypass frees: an id freed in cycle N is allocatable from cycle N+1.
REQ-013 SHALL advance CH by popcount(retire_i) on the next edge.
REQ-014 SHALL, on flush_i, set SH to CH+popcount(retire_i) on the next edge; frees in the same cycle SHALL still be written.
REQ-015 SHALL compute next count as count_o - granted + freed on normal cycles and as (T_next - SH_next) mod DEPTH on flush, with full state distinguished from empty by the counter.
REQ-016 SHALL drop a free that would make the occupancy exceed DEPTH and set overflow_o, which SHALL hold until reset.
REQ-017 SHALL set overflow_o when a retire would advance CH past SH.
REQ-018 SHALL leave CH unchanged after such an error; it SHALL NOT clip CH.
REQ-019 SHALL drive alloc_gnt_o to 0 whenever empty_o is 1, regardless of requests.

Reset
REQ-020 SHALL, while rst_ni is 0, set entry j to NR_RESERVED+j, T=0 (full), SH=CH=0, count_o=DEPTH, empty_o=0, overflow_o=0, alloc_gnt_o=0.
REQ-021 SHALL take effect immediately on rst_ni assertion, including mid-burst, and SHALL discard all in-flight state.
REQ-022 SHALL ignore all inputs on the first edge after rst_ni deasserts only if they are sampled while rst_ni is still 0.

Verification
REQ-023 Reset, then alloc_req_i=2'b11 for 3 cycles -> ids (32,33),(34,35),(36,37); count_o 32->30->28->26.
REQ-024 With count_o=1, alloc_req_i=2'b11 -> alloc_gnt_o=00 and count_o stays 1; then alloc_req_i=2'b10 -> port1 granted id at SH, count_o=0, empty_o=1.
REQ-025 Alloc 32..35, retire 2, then flush_i -> next alloc_req_i=2'b01 returns 34 and count_o=30.
REQ-026 Drain to empty, then free_id_i=7 -> same cycle alloc_gnt_o=0; next cycle alloc returns 7.
REQ-027 At count_o=32, free_valid_i=1 with id 3 -> entry dropped, overflow_o=1 sticky, count_o stays 32.
REQ-028 Assert rst_ni=0 mid-burst with count_o=20 -> count_o=32, overflow_o=0, and the next alloc returns 32 asynchronously to clk_i.
